dof_stage: RTL and testbench
============================

DOF_STAGE -- requirements
Module: dof_stage

Interface
REQ-001 Parameter DW, 32, datapath width of PC, register data and buses.
REQ-002 Parameter RAW, 5, register address width; register 0 reads as zero.
REQ-003 Parameter IMW, 15, immediate field width, IR[IMW-1:0].
REQ-004 Parameter CNTW, 16, stall counter width.
REQ-005 CLOCK  in  1  single clock; all state updates on rising edge.
REQ-006 RESET  in  1  asynchronous, active-low reset.
REQ-007 in_valid / in_ready  in / out  1 / 1  handshake from instruction fetch.
REQ-008 PC_M1 / IR  in  DW / 32  fetched PC+1 and instruction.
REQ-009 flush  in  1  branch/jump taken downstream; squash this stage.
REQ-010 AA / BA  out  RAW  register-file read addresses.
REQ-011 A_DATA / B_DATA  in  DW  register-file read data for AA / BA.
REQ-012 ex_valid, ex_rw, ex_load  in  1  EX-stage instruction valid, writes register, is memory load.
REQ-013 ex_da, ex_data  in  RAW, DW  EX destination and ALU result.
REQ-014 wb_valid, wb_rw  in  1; wb_da, wb_data  in  RAW, DW  WB destination and result.
REQ-015 out_valid / out_ready  out / in  1 / 1  handshake to EX.
REQ-016 BUS_A, BUS_B  out  DW  selected operands.
REQ-017 RW, DA, MD, BS, PS, MW, FS, SH  out  1, RAW, 2, 2, 1, 1, 5, 5  decoded controls.
REQ-018 stall_cnt  out  CNTW  count of hazard-stall cycles.

Function
REQ-019 Stage register {valid_q, pc_q, ir_q} SHALL load PC_M1, IR and valid_q<=1 when in_valid && in_ready.
REQ-020 valid_q SHALL clear on a cycle with out_valid && out_ready and no new load.
REQ-021 in_ready SHALL equal !valid_q || (out_ready && !hazard).
REQ-022 Decoding SHALL be combinational from ir_q; AA, BA, DA, SH and controls change only when ir_q changes.
REQ-023 Operand A SHALL be forwarded by priority: AA==0 -> 0; EX match (ex_valid && ex_rw && ex_da==AA && !ex_load) -> ex_data; WB match -> wb_data; else A_DATA. Operand B identical with BA.
REQ-024 hazard SHALL assert when valid_q && ex_valid && ex_rw && ex_load && ex_da!=0 && ex_da matches AA (if MA=0) or BA (if MB=0).
REQ-025 While hazard, out_valid SHALL be 0 and stage register SHALL hold.
REQ-026 Constant SHALL be IM sign-extended (CS=1) or zero-filled (CS=0) to DW.
REQ-027 BUS_A SHALL be pc_q when MA=1, else forwarded A; BUS_B SHALL be constant when MB=1, else forwarded B.
REQ-028 out_valid SHALL equal valid_q && !hazard && !flush.
REQ-029 When out_valid=0, RW and MW SHALL be 0 and BS SHALL be 0 (bubble); other controls are don't-care.
REQ-030 flush SHALL clear valid_q next edge and block loading that cycle (in_ready=0); flush wins over hazard and load.
REQ-031 stall_cnt SHALL increment each cycle hazard=1, saturating at all-ones, never wrapping.

Reset
REQ-032 RESET low SHALL immediately clear valid_q, pc_q, ir_q (ir_q=0 decodes as NOP) and stall_cnt.
REQ-033 During and after reset until first load: out_valid=0, in_ready=1, RW=0, MW=0, BS=0, BUS_A=BUS_B=0.
REQ-034 Reset mid-stall SHALL discard the held instruction; no output handshake completes.

Structure
REQ-035 Opcode values, control field widths, MD load encoding and the decode table SHALL live in shared package risc_pkg.
REQ-036 One sub-module dof_decode (combinational ir -> controls, MA, MB, CS) SHALL be instantiated; forwarding, hazard, constant and stage register stay in dof_stage.

Verification
REQ-037 Reset: RESET low with in_valid=1 -> out_valid=0, in_ready=1, stall_cnt=0, RW=MW=0.
REQ-038 Forward: ADD R3,R1,R2 with ex_da=1, ex_data=0x55, wb_da=1, wb_data=0x11, A_DATA=0x7 -> BUS_A=0x55; with EX invalid -> 0x11.
REQ-039 R0: AA=0, ex_da=0, ex_rw=1, ex_data=0xFFFF -> BUS_A=0.
REQ-040 Load-use: EX load to R4, next instruction reads R4 -> exactly one cycle out_valid=0, in_ready=0, stall_cnt=1, then out_valid=1 with forwarded WB data.
REQ-041 Flush: valid ADDI in stage, flush=1 -> out_valid=0 that cycle, valid_q=0 next cycle, no RW/MW pulse.
REQ-042 Constant/backpressure: ADDI with IM=0x4000, CS=1, DW=32 -> BUS_B=0xFFFFC000; out_ready=0 for 3 cycles -> outputs held stable, in_ready=0.

Source files
------------

// File: rtl/risc_pkg.sv
// Shared RISC definitions: opcodes, control field encodings and the opcode decode table.
package risc_pkg;

    localparam int OPW = 7;
    localparam int FSW = 5;
    localparam int MDW = 2;
    localparam int BSW = 2;
    localparam int SHW = 5;

    typedef enum logic [OPW-1:0] {
        OP_NOP = 7'h00,
        OP_ADD = 7'h02,
        OP_SUB = 7'h05,
        OP_AND = 7'h08,
        OP_OR  = 7'h09,
        OP_XOR = 7'h0A,
        OP_NOT = 7'h0B,
        OP_LSL = 7'h0C,
        OP_LSR = 7'h0D,
        OP_LD  = 7'h10,
        OP_ST  = 7'h20,
        OP_ADI = 7'h22,
        OP_SBI = 7'h25,
        OP_ANI = 7'h28,
        OP_ORI = 7'h29,
        OP_MOV = 7'h40,
        OP_BNZ = 7'h48,
        OP_BZ  = 7'h60,
        OP_JMP = 7'h61,
        OP_SLT = 7'h65,
        OP_JMR = 7'h70
    } opcode_e;

    // MD selects the write-back source; MD_MEM marks a load
    localparam logic [MDW-1:0] MD_FUNC = 2'b00;
    localparam logic [MDW-1:0] MD_MEM  = 2'b01;
    localparam logic [MDW-1:0] MD_SLT  = 2'b10;

    localparam logic [BSW-1:0] BS_NONE = 2'b00;
    localparam logic [BSW-1:0] BS_COND = 2'b01;
    localparam logic [BSW-1:0] BS_JREG = 2'b10;
    localparam logic [BSW-1:0] BS_JMP  = 2'b11;

    localparam logic [FSW-1:0] FS_PASS = 5'b00000;
    localparam logic [FSW-1:0] FS_ADD  = 5'b00010;
    localparam logic [FSW-1:0] FS_SUB  = 5'b00101;
    localparam logic [FSW-1:0] FS_AND  = 5'b01000;
    localparam logic [FSW-1:0] FS_OR   = 5'b01001;
    localparam logic [FSW-1:0] FS_XOR  = 5'b01010;
    localparam logic [FSW-1:0] FS_NOT  = 5'b01011;
    localparam logic [FSW-1:0] FS_LSR  = 5'b10100;
    localparam logic [FSW-1:0] FS_LSL  = 5'b11000;

    typedef struct packed {
        logic           rw;
        logic [MDW-1:0] md;
        logic [BSW-1:0] bs;
        logic           ps;
        logic           mw;
        logic [FSW-1:0] fs;
        logic           ma;
        logic           mb;
        logic           cs;
    } ctrl_t;

    // Unknown opcodes decode as NOP so they can never write state
    function automatic ctrl_t decode_op(input logic [OPW-1:0] op);
        ctrl_t c;
        c = '0;
        case (op)
            OP_ADD: begin c.rw = 1'b1; c.fs = FS_ADD; end
            OP_SUB: begin c.rw = 1'b1; c.fs = FS_SUB; end
            OP_AND: begin c.rw = 1'b1; c.fs = FS_AND; end
            OP_OR:  begin c.rw = 1'b1; c.fs = FS_OR;  end
            OP_XOR: begin c.rw = 1'b1; c.fs = FS_XOR; end
            OP_NOT: begin c.rw = 1'b1; c.fs = FS_NOT; end
            OP_LSL: begin c.rw = 1'b1; c.fs = FS_LSL; end
            OP_LSR: begin c.rw = 1'b1; c.fs = FS_LSR; end
            OP_MOV: begin c.rw = 1'b1; c.fs = FS_PASS; end
            OP_SLT: begin c.rw = 1'b1; c.md = MD_SLT; c.fs = FS_SUB; end
            OP_LD:  begin c.rw = 1'b1; c.md = MD_MEM; c.fs = FS_PASS; end
            OP_ST:  begin c.mw = 1'b1; c.fs = FS_PASS; end
            OP_ADI: begin c.rw = 1'b1; c.fs = FS_ADD; c.mb = 1'b1; c.cs = 1'b1; end
            OP_SBI: begin c.rw = 1'b1; c.fs = FS_SUB; c.mb = 1'b1; c.cs = 1'b1; end
            OP_ANI: begin c.rw = 1'b1; c.fs = FS_AND; c.mb = 1'b1; end
            OP_ORI: begin c.rw = 1'b1; c.fs = FS_OR;  c.mb = 1'b1; end
            OP_BZ:  begin c.bs = BS_COND; c.fs = FS_PASS; c.mb = 1'b1; c.cs = 1'b1; end
            OP_BNZ: begin c.bs = BS_COND; c.ps = 1'b1; c.fs = FS_PASS; c.mb = 1'b1; c.cs = 1'b1; end
            OP_JMR: begin c.bs = BS_JREG; c.fs = FS_PASS; end
            OP_JMP: begin c.bs = BS_JMP; c.fs = FS_ADD; c.ma = 1'b1; c.mb = 1'b1; c.cs = 1'b1; end
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/dof_decode.sv
// Instruction decoder: combinational IR -> register addresses, shift, immediate, controls.
// Zero latency; no state, no flow control.
module dof_decode
    import risc_pkg::*;
#(
    parameter int RAW = 5,
    parameter int IMW = 15
) (
    input  logic [31:0]    ir,
    output logic [RAW-1:0] da,
    output logic [RAW-1:0] aa,
    output logic [RAW-1:0] ba,
    output logic [SHW-1:0] sh,
    output logic [IMW-1:0] im,
    output ctrl_t          ctrl
);

    always_comb begin
        da   = ir[24 -: RAW];
        aa   = ir[19 -: RAW];
        ba   = ir[14 -: RAW];
        sh   = ir[SHW-1:0];
        im   = ir[IMW-1:0];
        ctrl = decode_op(ir[31:25]);
    end

endmodule

// File: rtl/dof_stage.sv
// Decode/operand-fetch stage: one-entry stage register, EX/WB forwarding, load-use stall.
// Latency 1 cycle from fetch handshake to out_valid; holds on out_ready=0 or load-use hazard.
module dof_stage
    import risc_pkg::*;
#(
    parameter int DW   = 32,
    parameter int RAW  = 5,
    parameter int IMW  = 15,
    parameter int CNTW = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [DW-1:0]   PC_M1,
    input  logic [31:0]     IR,
    input  logic            flush,
    output logic [RAW-1:0]  AA,
    output logic [RAW-1:0]  BA,
    input  logic [DW-1:0]   A_DATA,
    input  logic [DW-1:0]   B_DATA,
    input  logic            ex_valid,
    input  logic            ex_rw,
    input  logic            ex_load,
    input  logic [RAW-1:0]  ex_da,
    input  logic [DW-1:0]   ex_data,
    input  logic            wb_valid,
    input  logic            wb_rw,
    input  logic [RAW-1:0]  wb_da,
    input  logic [DW-1:0]   wb_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [DW-1:0]   BUS_A,
    output logic [DW-1:0]   BUS_B,
    output logic            RW,
    output logic [RAW-1:0]  DA,
    output logic [MDW-1:0]  MD,
    output logic [BSW-1:0]  BS,
    output logic            PS,
    output logic            MW,
    output logic [FSW-1:0]  FS,
    output logic [SHW-1:0]  SH,
    output logic [CNTW-1:0] stall_cnt
);

    logic            valid_q, valid_d;
    logic [DW-1:0]   pc_q, pc_d;
    logic [31:0]     ir_q, ir_d;
    logic [CNTW-1:0] stall_cnt_q, stall_cnt_d;

    logic [IMW-1:0]  im;
    ctrl_t           ctrl;
    logic            hazard;
    logic            load;
    logic [DW-1:0]   fwd_a, fwd_b, konst;

    dof_decode #(.RAW(RAW), .IMW(IMW)) u_decode (
        .ir   (ir_q),
        .da   (DA),
        .aa   (AA),
        .ba   (BA),
        .sh   (SH),
        .im   (im),
        .ctrl (ctrl)
    );

    // A load in EX has no data yet, so it is never a forwarding source
    function automatic logic [DW-1:0] fwd(input logic [RAW-1:0] addr, input logic [DW-1:0] rf);
        if (addr == '0)
            return '0;
        else if (ex_valid && ex_rw && !ex_load && ex_da == addr)
            return ex_data;
        else if (wb_valid && wb_rw && wb_da == addr)
            return wb_data;
        else
            return rf;
    endfunction

    always_comb begin
        fwd_a  = fwd(AA, A_DATA);
        fwd_b  = fwd(BA, B_DATA);
        konst  = {{(DW-IMW){im[IMW-1] & ctrl.cs}}, im};
        hazard = valid_q && ex_valid && ex_rw && ex_load && (ex_da != '0) &&
                 ((!ctrl.ma && ex_da == AA) || (!ctrl.mb && ex_da == BA));

        out_valid = valid_q && !hazard && !flush;
        in_ready  = !flush && (!valid_q || (out_ready && !hazard));
        load      = in_valid && in_ready;

        BUS_A = ctrl.ma ? pc_q  : fwd_a;
        BUS_B = ctrl.mb ? konst : fwd_b;
        RW    = ctrl.rw && out_valid;
        MW    = ctrl.mw && out_valid;
        BS    = out_valid ? ctrl.bs : BS_NONE;
        MD    = ctrl.md;
        PS    = ctrl.ps;
        FS    = ctrl.fs;
        stall_cnt = stall_cnt_q;
    end

    always_comb begin
        valid_d     = valid_q;
        pc_d        = pc_q;
        ir_d        = ir_q;
        stall_cnt_d = stall_cnt_q;
        if (flush)
            valid_d = 1'b0;
        else if (load)
            valid_d = 1'b1;
        else if (out_valid && out_ready)
            valid_d = 1'b0;
        if (load) begin
            pc_d = PC_M1;
            ir_d = IR;
        end
        if (hazard && stall_cnt_q != '1)
            stall_cnt_d = stall_cnt_q + CNTW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q     <= 1'b0;
            pc_q        <= '0;
            ir_q        <= '0;
            stall_cnt_q <= '0;
        end else begin
            valid_q     <= valid_d;
            pc_q        <= pc_d;
            ir_q        <= ir_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

endmodule

// File: tb/tb_dof_stage.sv
// Directed-vector bench for dof_stage with hand-computed expected values.
module tb_dof_stage;
    import risc_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, flush;
    logic [31:0] PC_M1, IR;
    logic [4:0]  AA, BA, DA, SH;
    logic [31:0] A_DATA, B_DATA;
    logic        ex_valid, ex_rw, ex_load;
    logic [4:0]  ex_da, wb_da;
    logic [31:0] ex_data, wb_data;
    logic        wb_valid, wb_rw;
    logic        out_valid, out_ready;
    logic [31:0] BUS_A, BUS_B;
    logic        RW, PS, MW;
    logic [1:0]  MD, BS;
    logic [4:0]  FS;
    logic [15:0] stall_cnt;

    int n_chk = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    dof_stage #(.DW(32), .RAW(5), .IMW(15), .CNTW(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .PC_M1(PC_M1), .IR(IR), .flush(flush), .AA(AA), .BA(BA),
        .A_DATA(A_DATA), .B_DATA(B_DATA), .ex_valid(ex_valid), .ex_rw(ex_rw),
        .ex_load(ex_load), .ex_da(ex_da), .ex_data(ex_data), .wb_valid(wb_valid),
        .wb_rw(wb_rw), .wb_da(wb_da), .wb_data(wb_data), .out_valid(out_valid),
        .out_ready(out_ready), .BUS_A(BUS_A), .BUS_B(BUS_B), .RW(RW), .DA(DA),
        .MD(MD), .BS(BS), .PS(PS), .MW(MW), .FS(FS), .SH(SH), .stall_cnt(stall_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] mk(input logic [6:0] op, input logic [4:0] dr,
                                       input logic [4:0] sa, input logic [14:0] imf);
        return {op, dr, sa, imf};
    endfunction

    function automatic logic [31:0] rr(input logic [6:0] op, input logic [4:0] dr,
                                       input logic [4:0] sa, input logic [4:0] sb);
        return mk(op, dr, sa, {sb, 10'd0});
    endfunction

    initial begin
        rst_n = 1'b0; in_valid = 1'b1; flush = 1'b0; out_ready = 1'b0;
        PC_M1 = 32'h10; IR = rr(OP_ADD, 5'd3, 5'd1, 5'd2);
        A_DATA = 32'h7; B_DATA = 32'h22;
        ex_valid = 1'b0; ex_rw = 1'b0; ex_load = 1'b0; ex_da = '0; ex_data = '0;
        wb_valid = 1'b0; wb_rw = 1'b0; wb_da = '0; wb_data = '0;

        // reset with in_valid high
        #3;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready",  32'(in_ready),  32'd1);
        chk("rst_stall",     32'(stall_cnt), 32'd0);
        chk("rst_rw_mw_bs",  {29'd0, RW, MW, BS != 2'b00}, 32'd0);
        chk("rst_bus_a",     BUS_A, 32'd0);
        chk("rst_bus_b",     BUS_B, 32'd0);
        #4 rst_n = 1'b1;

        // ADD R3,R1,R2 loads on next edge; forwarding priority EX > WB > RF
        step();
        in_valid = 1'b0;
        ex_valid = 1'b1; ex_rw = 1'b1; ex_da = 5'd1; ex_data = 32'h55;
        wb_valid = 1'b1; wb_rw = 1'b1; wb_da = 5'd1; wb_data = 32'h11;
        #1;
        chk("add_out_valid", 32'(out_valid), 32'd1);
        chk("add_aa_ba_da",  {17'd0, AA, BA, DA}, {17'd0, 5'd1, 5'd2, 5'd3});
        chk("fwd_ex",        BUS_A, 32'h55);
        chk("fwd_b_rf",      BUS_B, 32'h22);
        chk("add_rw_fs",     {26'd0, RW, FS}, {26'd0, 1'b1, FS_ADD});
        ex_valid = 1'b0; #1;
        chk("fwd_wb",        BUS_A, 32'h11);
        wb_valid = 1'b0; #1;
        chk("fwd_rf",        BUS_A, 32'h7);

        // retire ADD while loading ADD R6,R0,R2
        out_ready = 1'b1; in_valid = 1'b1; IR = rr(OP_ADD, 5'd6, 5'd0, 5'd2);
        step();
        in_valid = 1'b0; out_ready = 1'b0;
        ex_valid = 1'b1; ex_rw = 1'b1; ex_load = 1'b0; ex_da = 5'd0; ex_data = 32'hFFFF;
        A_DATA = 32'h1234; #1;
        chk("r0_bus_a",      BUS_A, 32'd0);
        ex_da = 5'd2; #1;
        chk("fwd_ex_b",      BUS_B, 32'hFFFF);

        // load-use: EX loads R4, ADD R5,R4,R2 in stage
        out_ready = 1'b1; in_valid = 1'b1; IR = rr(OP_ADD, 5'd5, 5'd4, 5'd2); ex_valid = 1'b0;
        step();
        in_valid = 1'b0;
        ex_valid = 1'b1; ex_rw = 1'b1; ex_load = 1'b1; ex_da = 5'd4; #1;
        chk("lu_out_valid",  32'(out_valid), 32'd0);
        chk("lu_in_ready",   32'(in_ready),  32'd0);
        chk("lu_rw",         32'(RW),        32'd0);
        chk("lu_stall_pre",  32'(stall_cnt), 32'd0);
        step();
        chk("lu_stall_post", 32'(stall_cnt), 32'd1);
        ex_valid = 1'b0; ex_load = 1'b0;
        wb_valid = 1'b1; wb_rw = 1'b1; wb_da = 5'd4; wb_data = 32'hABC; #1;
        chk("lu_resume",     32'(out_valid), 32'd1);
        chk("lu_fwd_wb",     BUS_A, 32'hABC);
        chk("lu_in_ready2",  32'(in_ready),  32'd1);
        step();
        wb_valid = 1'b0; #1;
        chk("lu_retired",    32'(out_valid), 32'd0);
        chk("lu_stall_hold", 32'(stall_cnt), 32'd1);

        // ADI R7,R1,0x4000: sign-extended constant; EX load matching the BA field must not stall
        out_ready = 1'b0; in_valid = 1'b1; PC_M1 = 32'h100;
        IR = mk(OP_ADI, 5'd7, 5'd1, 15'h4000);
        step();
        IR = rr(OP_SUB, 5'd9, 5'd9, 5'd9);
        ex_valid = 1'b1; ex_rw = 1'b1; ex_load = 1'b1; ex_da = 5'd16; #1;
        chk("adi_no_hazard", 32'(out_valid), 32'd1);
        chk("adi_bus_b",     BUS_B, 32'hFFFFC000);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("bp_bus_b",    BUS_B, 32'hFFFFC000);
            chk("bp_bus_a",    BUS_A, 32'h1234);
            chk("bp_da",       32'(DA), 32'd7);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            chk("bp_out_valid", 32'(out_valid), 32'd1);
        end
        chk("bp_stall",      32'(stall_cnt), 32'd1);

        // flush squashes the held ADI and blocks the pending fetch
        flush = 1'b1; #1;
        chk("fl_out_valid",  32'(out_valid), 32'd0);
        chk("fl_in_ready",   32'(in_ready),  32'd0);
        chk("fl_rw_mw",      {30'd0, RW, MW}, 32'd0);
        step();
        flush = 1'b0; in_valid = 1'b0; ex_valid = 1'b0; ex_load = 1'b0; #1;
        chk("fl_cleared",    32'(out_valid), 32'd0);
        chk("fl_rw_after",   32'(RW), 32'd0);

        // ANI zero-fills; JMP uses PC and sign-extended offset
        out_ready = 1'b1; in_valid = 1'b1; IR = mk(OP_ANI, 5'd2, 5'd1, 15'h4000);
        step();
        chk("ani_bus_b",     BUS_B, 32'h00004000);
        PC_M1 = 32'h200; IR = mk(OP_JMP, 5'd0, 5'd0, 15'h7FFF);
        step();
        chk("jmp_bus_a",     BUS_A, 32'h200);
        chk("jmp_bus_b",     BUS_B, 32'hFFFFFFFF);
        chk("jmp_bs_rw",     {29'd0, RW, BS}, {29'd0, 1'b0, BS_JMP});
        IR = rr(OP_ST, 5'd0, 5'd1, 5'd2);
        step();
        in_valid = 1'b0; out_ready = 1'b0; #1;
        chk("st_mw_rw",      {30'd0, MW, RW}, 32'd2);
        chk("st_bus_b",      BUS_B, 32'h22);

        // reset during a load-use stall discards the held ST
        ex_valid = 1'b1; ex_rw = 1'b1; ex_load = 1'b1; ex_da = 5'd1; #1;
        chk("ms_stalled",    32'(in_ready), 32'd0);
        rst_n = 1'b0; #1;
        chk("ms_out_valid",  32'(out_valid), 32'd0);
        chk("ms_in_ready",   32'(in_ready),  32'd1);
        chk("ms_stall_clr",  32'(stall_cnt), 32'd0);
        chk("ms_mw",         32'(MW), 32'd0);
        #2 rst_n = 1'b1;
        out_ready = 1'b1;
        step();
        chk("ms_discarded",  32'(out_valid), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_chk, n_bad);
        $finish;
    end

endmodule
